// File: rtl/uart_rx_oversample_if.sv
// Serial receive bus for uart_rx_oversample.
//   rx        : asynchronous serial line into the receiver, idle high
//   rx_data   : last correctly framed byte
//   rx_ready  : one-cycle strobe, rx_data valid in the same cycle
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver is inside a frame
// master = receiver side, slave = consumer side (drives rx in a bench or pad model).
interface uart_rx_oversample_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_ready,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_ready,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver, 8N1, LSB first, with 3-sample majority voting and start-bit
// validation. Delivers one byte per good frame with a single-cycle strobe; stop-bit errors
// produce a frame_err strobe instead and never update rx_data.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous reset, active low
//   bus : uart_rx_oversample_if.master (rx in; rx_data, rx_ready, frame_err, busy out)
module uart_rx_oversample #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_oversample_if.master bus
);

    localparam int unsigned DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned M   = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DivMax   = DW'(DIV - 1);
    localparam logic [SW-1:0] SampM1   = SW'(M - 1);
    localparam logic [SW-1:0] SampM    = SW'(M);
    localparam logic [SW-1:0] SampP1   = SW'(M + 1);
    localparam logic [SW-1:0] SampLast = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [DW-1:0] div_cnt_q;
    logic [SW-1:0] samp_cnt_q;
    logic [1:0]    vote_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_ready_q;
    logic          frame_err_q;

    logic rx_s;
    logic tick;
    logic vote;

    assign rx_s = sync_q[1];
    // div_cnt is held at 0 in idle, so no tick can occur there.
    assign tick = (state_q != StIdle) && (div_cnt_q == DivMax);
    // Third vote is the live sample taken at M+1.
    assign vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            div_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            vote_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.rx};
            rx_prev_q   <= rx_s;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == StIdle || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end

            if (tick) begin
                samp_cnt_q <= (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + 1'b1;
                if (samp_cnt_q == SampM1) vote_q[0] <= rx_s;
                if (samp_cnt_q == SampM)  vote_q[1] <= rx_s;
            end

            case (state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q    <= StStart;
                        samp_cnt_q <= '0;
                        vote_q     <= '0;
                        bit_idx_q  <= '0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (samp_cnt_q == SampP1 && vote) begin
                            state_q <= StIdle;  // glitch, not a real start bit
                        end else if (samp_cnt_q == SampLast) begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        if (samp_cnt_q == SampP1) begin
                            shift_q <= {vote, shift_q[7:1]};
                        end
                        if (samp_cnt_q == SampLast) begin
                            if (bit_idx_q == 3'd7) begin
                                state_q <= StStop;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                end
                StStop: begin
                    // Decide at mid stop bit and leave at once, so back-to-back frames and
                    // short stop bits are tolerated.
                    if (tick && samp_cnt_q == SampP1) begin
                        if (vote) begin
                            rx_data_q  <= shift_q;
                            rx_ready_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_ready  = rx_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
